// File: rtl/uart_rx_checker_pkg.sv
// Shared types and constants for the UART receive checker.
// The fixed 16-byte test pattern matches the on-board test transmitter.
package uart_pkg;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // 27 MHz / 115200 baud, rounded down.
    localparam int CLKS_PER_BIT_115200 = 234;

    localparam int PATTERN_LEN = 16;

    // Test pattern, index 0 in the least significant byte:
    // "MISTYSTINKS!", CR, LF, 0xBE, 0xEF.
    localparam logic [PATTERN_LEN-1:0][7:0] PATTERN = {
        8'hEF, 8'hBE, 8'h0A, 8'h0D,
        8'h21, 8'h53, 8'h4B, 8'h4E,
        8'h49, 8'h54, 8'h53, 8'h59,
        8'h54, 8'h53, 8'h49, 8'h4D
    };

endpackage

// File: rtl/uart_rx_checker_if.sv
// Serial input plus receive/status outputs of the UART receive checker.
// master: the side that drives the serial line (board harness / bench).
// slave:  the checker itself.
interface uart_rx_checker_if #(
    parameter int CNT_W = 16
);
    logic             uart_rx;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             frame_err;
    logic             locked;
    logic [CNT_W-1:0] good_count;
    logic [CNT_W-1:0] err_count;
    logic [5:0]       led;

    modport master (
        output uart_rx,
        input  rx_data, rx_valid, frame_err, locked, good_count, err_count, led
    );

    modport slave (
        input  uart_rx,
        output rx_data, rx_valid, frame_err, locked, good_count, err_count, led
    );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchronizer, bit-timing FSM, LSB-first shifter.
// Optional build macro UART_RX_GLITCH_FILTER_EN: each bit sample becomes the
// majority of the synchronized line over the current and two previous cycles.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int CLK_CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CLK_CNT_W-1:0] HALF_LAST = CLK_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CLK_CNT_W-1:0] BIT_LAST  = CLK_CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]           sync_reg;
    logic [1:0]           primed_reg;
    logic                 line;
    logic                 sample_bit;

    rx_state_t            state_reg, state_next;
    logic [CLK_CNT_W-1:0] clk_cnt_reg, clk_cnt_next;
    logic [2:0]           bit_idx_reg, bit_idx_next;
    logic [7:0]           shift_reg, shift_next;
    logic [7:0]           rx_data_reg, rx_data_next;
    logic                 rx_valid_reg, rx_valid_next;
    logic                 frame_err_reg, frame_err_next;

    // Two-flop synchronizer; reset to idle-high. primed_reg marks when the
    // synchronizer holds real pin samples instead of its reset value, so
    // WAIT_HIGH cannot be satisfied by the reset value alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg   <= 2'b11;
            primed_reg <= 2'b00;
        end else begin
            sync_reg   <= {sync_reg[0], uart_rx};
            primed_reg <= {primed_reg[0], 1'b1};
        end
    end

    assign line = sync_reg[1];

`ifdef UART_RX_GLITCH_FILTER_EN
    logic [1:0] hist_reg;

    // History of the two previous synchronized values for the majority vote.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_reg <= 2'b11;
        end else begin
            hist_reg <= {hist_reg[0], line};
        end
    end

    assign sample_bit = (line & hist_reg[0]) | (line & hist_reg[1]) |
                        (hist_reg[0] & hist_reg[1]);
`else
    assign sample_bit = line;
`endif

    // FSM and datapath state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= WAIT_HIGH;
            clk_cnt_reg   <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            clk_cnt_reg   <= clk_cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            rx_data_reg   <= rx_data_next;
            rx_valid_reg  <= rx_valid_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // Next-state logic: bit timing, sampling and frame completion.
    always_comb begin
        state_next     = state_reg;
        clk_cnt_next   = clk_cnt_reg;
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        rx_data_next   = rx_data_reg;
        rx_valid_next  = 1'b0;
        frame_err_next = 1'b0;

        case (state_reg)
            WAIT_HIGH: begin
                // Do not arm on a line that is still low after reset or a break.
                if (line && primed_reg[1]) begin
                    state_next = IDLE;
                end
            end

            IDLE: begin
                if (!line) begin
                    state_next   = START;
                    clk_cnt_next = '0;
                end
            end

            START: begin
                if (clk_cnt_reg == HALF_LAST) begin
                    clk_cnt_next = '0;
                    if (sample_bit) begin
                        state_next = IDLE;          // start-bit glitch
                    end else begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end

            DATA: begin
                if (clk_cnt_reg == BIT_LAST) begin
                    clk_cnt_next = '0;
                    shift_next   = {sample_bit, shift_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end

            STOP: begin
                if (clk_cnt_reg == BIT_LAST) begin
                    clk_cnt_next = '0;
                    if (sample_bit) begin
                        rx_data_next  = shift_reg;
                        rx_valid_next = 1'b1;
                        state_next    = IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = WAIT_HIGH;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = WAIT_HIGH;
            end
        endcase
    end

    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: rtl/uart_rx_checker.sv
// UART receive checker: receives 8N1 bytes and compares them with the fixed
// 16-byte test pattern, tracking lock, saturating counts and LED status.
// Optional build macro UART_RX_GLITCH_FILTER_EN enables the receiver's
// 3-sample majority filter.
module uart_rx_checker
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    uart_rx_checker_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [3:0]       IDX_LAST = 4'(PATTERN_LEN - 1);

    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             frame_err;

    logic [3:0]       exp_idx_reg;
    logic             locked_reg;
    logic             frame_err_sticky_reg;
    logic             mismatch_sticky_reg;
    logic [CNT_W-1:0] good_count_reg;
    logic [CNT_W-1:0] err_count_reg;
    logic [5:0]       status;
    logic [5:0]       led_n;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (bus.uart_rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err)
    );

    // Pattern tracking, lock and saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_idx_reg          <= '0;
            locked_reg           <= 1'b0;
            frame_err_sticky_reg <= 1'b0;
            mismatch_sticky_reg  <= 1'b0;
            good_count_reg       <= '0;
            err_count_reg        <= '0;
        end else if (rx_valid) begin
            if (rx_data == PATTERN[exp_idx_reg]) begin
                if (good_count_reg != CNT_MAX) begin
                    good_count_reg <= good_count_reg + 1'b1;
                end
                exp_idx_reg <= exp_idx_reg + 1'b1;   // 4-bit index wraps 15 -> 0
                if (exp_idx_reg == IDX_LAST) begin
                    locked_reg <= 1'b1;
                end
            end else begin
                if (err_count_reg != CNT_MAX) begin
                    err_count_reg <= err_count_reg + 1'b1;
                end
                mismatch_sticky_reg <= 1'b1;
                locked_reg          <= 1'b0;
                // A wrong byte that is itself the pattern start begins a new run.
                exp_idx_reg <= (rx_data == PATTERN[0]) ? 4'd1 : 4'd0;
            end
        end else if (frame_err) begin
            if (err_count_reg != CNT_MAX) begin
                err_count_reg <= err_count_reg + 1'b1;
            end
            frame_err_sticky_reg <= 1'b1;
            locked_reg           <= 1'b0;
            exp_idx_reg          <= '0;
        end
    end

    // Active-low LEDs.
    assign status = {locked_reg, frame_err_sticky_reg, mismatch_sticky_reg, exp_idx_reg[2:0]};

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_led
            assign led_n[gi] = ~status[gi];
        end
    endgenerate

    assign bus.rx_data    = rx_data;
    assign bus.rx_valid   = rx_valid;
    assign bus.frame_err  = frame_err;
    assign bus.locked     = locked_reg;
    assign bus.good_count = good_count_reg;
    assign bus.err_count  = err_count_reg;
    assign bus.led        = led_n;

endmodule

// File: tb/tb_uart_rx_checker.sv
// Scoreboard bench for uart_rx_checker: stimulus pushes expected receive
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_uart_rx_checker;

    localparam int CPB = 16;
    localparam int CW  = 6;

    typedef struct packed {
        logic       is_ferr;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    logic [7:0] pat [16] = '{8'h4D, 8'h49, 8'h53, 8'h54, 8'h59, 8'h53, 8'h54, 8'h49,
                             8'h4E, 8'h4B, 8'h53, 8'h21, 8'h0D, 8'h0A, 8'hBE, 8'hEF};

    uart_rx_checker_if #(.CNT_W(CW)) bus ();

    uart_rx_checker #(
        .CLKS_PER_BIT(CPB),
        .CNT_W       (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Monitor: every rx_valid / frame_err cycle consumes one expected event.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (bus.rx_valid || bus.frame_err)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output actual rx_valid=%0b frame_err=%0b rx_data=%02h required none",
                         bus.rx_valid, bus.frame_err, bus.rx_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.frame_err !== e.is_ferr || bus.rx_valid !== !e.is_ferr ||
                    (!e.is_ferr && bus.rx_data !== e.data)) begin
                    failures++;
                    $display("FAIL rx_event actual valid=%0b ferr=%0b data=%02h required ferr=%0b data=%02h",
                             bus.rx_valid, bus.frame_err, bus.rx_data, e.is_ferr, e.data);
                end else if (e.is_ferr) begin
                    $display("rx frame_err ok");
                end else begin
                    $display("rx byte %02h ok", bus.rx_data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        bus.uart_rx = v;
        repeat (n) @(negedge clk);
    endtask

    // One frame; spike_bit >= 0 puts a 1-cycle low spike at that data bit's sample point.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int spike_bit);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) begin
            if (i == spike_bit) begin
                drive_bit(b[i], CPB / 2);
                drive_bit(1'b0, 1);
                drive_bit(b[i], CPB / 2 - 1);
            end else begin
                drive_bit(b[i], CPB);
            end
        end
        drive_bit(stop_bit, CPB);
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_q.push_back('{is_ferr: 1'b0, data: b});
        send_frame(b, 1'b1, -1);
        drive_bit(1'b1, CPB);
    endtask

    task automatic check_drained(input string name);
        repeat (4) @(negedge clk);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        bus.uart_rx = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        exp_q.delete();
    endtask

    initial begin
        bus.uart_rx = 1'b1;

        // Reset state
        do_reset();
        check("reset_led", bus.led, 6'h3F);
        check("reset_good", bus.good_count, 0);
        check("reset_err", bus.err_count, 0);
        check("reset_locked", bus.locked, 0);
        check("reset_rx_valid", bus.rx_valid, 0);
        check("reset_frame_err", bus.frame_err, 0);
        check("reset_rx_data", bus.rx_data, 8'h00);

        // 1: single 'M'
        send_byte(8'h4D);
        check_drained("t1_drain");
        check("t1_rx_data", bus.rx_data, 8'h4D);
        check("t1_good", bus.good_count, 1);
        check("t1_err", bus.err_count, 0);
        check("t1_led", bus.led, 6'b111110);

        // 2: pattern twice, then twice more to hit good_count saturation
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 16; i++) begin
                send_byte(pat[i]);
                check("t2_locked", bus.locked, (r == 1 || i == 15) ? 1 : 0);
            end
        end
        check_drained("t2_drain");
        check("t2_good32", bus.good_count, 32);
        check("t2_err", bus.err_count, 0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 16; i++) begin
                send_byte(pat[i]);
            end
        end
        check_drained("t2_sat_drain");
        check("t2_good_sat", bus.good_count, 63);
        check("t2_sat_locked", bus.locked, 1);

        // 3: "MIS", 'X', "MIM"
        do_reset();
        send_byte(8'h4D);
        send_byte(8'h49);
        send_byte(8'h53);
        send_byte(8'h58);
        check("t3_err_x", bus.err_count, 1);
        check("t3_led_x", bus.led, 6'b110111);
        check("t3_locked_x", bus.locked, 0);
        send_byte(8'h4D);
        send_byte(8'h49);
        send_byte(8'h4D);
        check_drained("t3_drain");
        check("t3_err_m", bus.err_count, 2);
        check("t3_good", bus.good_count, 5);
        check("t3_led_m", bus.led, 6'b110110);

        // 4: framing error with a 3-bit-time break, then recovery
        do_reset();
        exp_q.push_back('{is_ferr: 1'b1, data: 8'h00});
        send_frame(8'h49, 1'b0, -1);
        drive_bit(1'b0, 3 * CPB);
        drive_bit(1'b1, 2 * CPB);
        check_drained("t4_drain");
        check("t4_err", bus.err_count, 1);
        check("t4_good", bus.good_count, 0);
        check("t4_led", bus.led, 6'b101111);
        send_byte(8'h4D);
        check_drained("t4_m_drain");
        check("t4_m_good", bus.good_count, 1);
        check("t4_m_led", bus.led, 6'b101110);

        // 5: short low glitch on an idle line
        do_reset();
        drive_bit(1'b0, 5);
        drive_bit(1'b1, 3 * CPB);
        check_drained("t5_drain");
        check("t5_good", bus.good_count, 0);
        check("t5_err", bus.err_count, 0);
        send_byte(8'h4D);
        check_drained("t5_m_drain");
        check("t5_m_good", bus.good_count, 1);

        // 6: reset mid data bit with the line low
        do_reset();
        drive_bit(1'b0, CPB);
        drive_bit(1'b0, CPB + CPB / 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive_bit(1'b0, 6 * CPB);
        drive_bit(1'b1, 2 * CPB);
        check_drained("t6_abort_drain");
        check("t6_abort_good", bus.good_count, 0);
        check("t6_abort_err", bus.err_count, 0);
        send_byte(8'h4D);
        check_drained("t6_m_drain");
        check("t6_m_good", bus.good_count, 1);
        check("t6_m_err", bus.err_count, 0);

`ifdef UART_RX_GLITCH_FILTER_EN
        // Filter: single-cycle spike at the bit-3 sample point of 0xFF
        do_reset();
        exp_q.push_back('{is_ferr: 1'b0, data: 8'hFF});
        send_frame(8'hFF, 1'b1, 3);
        drive_bit(1'b1, CPB);
        check_drained("t6_filter_drain");
        check("t6_filter_data", bus.rx_data, 8'hFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
